// File: rtl/uart_cmd_engine.sv
// Host command responder: drains RX FIFO bytes, parses 'W' addr data / 'R' addr
// packets against a small register file, and pushes one reply byte per command.
module uart_cmd_engine #(
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_empty,
  input  logic [7:0]            rx_byte,
  output logic                  rx_pop,
  input  logic                  tx_full,
  output logic [7:0]            tx_byte,
  output logic                  tx_push,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  cmd_err,
  output logic [7:0]            err_count,
  output logic                  busy
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, RSP_K = 8'h4B, RSP_Q = 8'h3F;

  typedef enum logic [3:0] {
    WAIT_OP, POP_OP, GET_OP, WAIT_ADDR, POP_ADDR, GET_ADDR,
    WAIT_DATA, POP_DATA, GET_DATA, EXEC, SEND
  } state_t;

  state_t                     state_q, state_d;
  logic                       rx_pop_q, rx_pop_d, tx_push_q, tx_push_d;
  logic                       cmd_err_q, cmd_err_d, busy_q, busy_d, err;
  logic [7:0]                 tx_byte_q, tx_byte_d, err_count_q, err_count_d;
  logic [7:0]                 op_q, op_d, addr_q, addr_d, data_q, data_d, reply_q, reply_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic                       addr_bad, tmo_hit;

  assign addr_bad = 32'(addr_q) >= 32'(NUM_REGS);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    rx_pop_d  = 1'b0;
    tx_push_d = 1'b0;
    tx_byte_d = tx_byte_q;
    regs_d    = regs_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    reply_d   = reply_q;
    tmo_d     = tmo_q;
    err       = 1'b0;
    case (state_q)
      WAIT_OP: if (!rx_empty) begin rx_pop_d = 1'b1; state_d = POP_OP; end
      POP_OP:  state_d = GET_OP;
      GET_OP: begin
        op_d  = rx_byte;
        tmo_d = '0;
        if (rx_byte == OP_W || rx_byte == OP_R) state_d = WAIT_ADDR;
        else begin reply_d = RSP_Q; err = 1'b1; state_d = SEND; end
      end
      WAIT_ADDR, WAIT_DATA: begin
        if (!rx_empty) begin
          rx_pop_d = 1'b1;
          state_d  = (state_q == WAIT_ADDR) ? POP_ADDR : POP_DATA;
        end else if (tmo_hit) begin
          // abandon the partial packet silently; the next byte is an opcode
          err     = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_OP;
        end else if (TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      POP_ADDR: state_d = GET_ADDR;
      GET_ADDR: begin
        addr_d  = rx_byte;
        tmo_d   = '0;
        state_d = (op_q == OP_W) ? WAIT_DATA : EXEC;
      end
      POP_DATA: state_d = GET_DATA;
      GET_DATA: begin
        data_d  = rx_byte;
        tmo_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (addr_bad) begin
          reply_d = RSP_Q;
          err     = 1'b1;
        end else if (op_q == OP_W) begin
          regs_d[addr_q[AW-1:0]] = data_q;
          reply_d                = RSP_K;
        end else begin
          reply_d = regs_q[addr_q[AW-1:0]];
        end
        state_d = SEND;
      end
      SEND: if (!tx_full) begin
        tx_push_d = 1'b1;
        tx_byte_d = reply_q;
        state_d   = WAIT_OP;
      end
      default: state_d = WAIT_OP;
    endcase
    cmd_err_d   = err;
    err_count_d = (err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    busy_d      = (state_d != WAIT_OP) || tx_push_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_OP;
      rx_pop_q    <= 1'b0;
      tx_push_q   <= 1'b0;
      tx_byte_q   <= 8'h00;
      cmd_err_q   <= 1'b0;
      err_count_q <= 8'h00;
      busy_q      <= 1'b0;
      op_q        <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      reply_q     <= 8'h00;
      tmo_q       <= '0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_pop_q    <= rx_pop_d;
      tx_push_q   <= tx_push_d;
      tx_byte_q   <= tx_byte_d;
      cmd_err_q   <= cmd_err_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reply_q     <= reply_d;
      tmo_q       <= tmo_d;
      regs_q      <= regs_d;
    end
  end

  assign rx_pop    = rx_pop_q;
  assign tx_push   = tx_push_q;
  assign tx_byte   = tx_byte_q;
  assign cmd_err   = cmd_err_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;
  assign regs_out  = regs_q;
endmodule

// File: tb/tb_uart_cmd_engine.sv
// Bench for uart_cmd_engine: RX FIFO model, TX/err monitor, command vector table
// and hand-written sequences for timeout, TX backpressure and mid-packet reset.
module tb_uart_cmd_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_pop;
  logic        tx_full = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_push;
  logic [63:0] regs_out;
  logic        cmd_err;
  logic [7:0]  err_count;
  logic        busy;

  uart_cmd_engine #(.NUM_REGS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_byte(rx_byte), .rx_pop(rx_pop),
    .tx_full(tx_full), .tx_byte(tx_byte), .tx_push(tx_push), .regs_out(regs_out),
    .cmd_err(cmd_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // RX FIFO model: the popped head appears mid pop-cycle and holds through the next cycle
  logic [7:0] rxq[$];
  always @(negedge clk) begin
    if (rx_pop) rx_byte = rxq.pop_front();
    rx_empty = (rxq.size() == 0);
  end

  int         push_cnt = 0, err_cnt = 0, wide_err = 0;
  logic [7:0] last_tx = 8'h00;
  logic       prev_err = 1'b0;
  always @(negedge clk) begin
    if (tx_push) begin push_cnt++; last_tx = tx_byte; end
    if (cmd_err) begin err_cnt++; if (prev_err) wide_err++; end
    prev_err = cmd_err;
  end

  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] mreg[8];
  int         merr = 0;
  function automatic logic [63:0] pack_regs();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mreg[i];
    return r;
  endfunction

  task automatic send_bytes(input logic [7:0] b0, b1, b2, input int n);
    @(negedge clk);
    rxq.push_back(b0);
    if (n > 1) rxq.push_back(b1);
    if (n > 2) rxq.push_back(b2);
  endtask

  task automatic do_cmd(input string name, input logic [7:0] b0, b1, b2, input int n,
                        input logic [7:0] exp_reply, input int exp_err);
    int  p0, e0;
    bit  ok;
    p0 = push_cnt;
    e0 = err_cnt;
    ok = 0;
    send_bytes(b0, b1, b2, n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (push_cnt != p0) begin ok = 1; break; end
    end
    repeat (6) @(negedge clk);
    if (exp_err != 0) merr = (merr < 255) ? merr + 1 : 255;
    else if (b0 == 8'h57) mreg[b1[2:0]] = b2;
    check({name, " reply_seen"}, 64'(ok), 64'd1);
    check({name, " push_count"}, 64'(push_cnt - p0), 64'd1);
    check({name, " reply"}, 64'(last_tx), 64'(exp_reply));
    check({name, " err_pulses"}, 64'(err_cnt - e0), 64'(exp_err));
    check({name, " err_count"}, 64'(err_count), 64'(merr));
    check({name, " regs"}, regs_out, pack_regs());
    check({name, " busy_idle"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] reply;
    int         err;
  } vec_t;
  vec_t v[8];

  initial begin
    int  p0, e0;
    bit  ok;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    v[0] = '{"wr3",   8'h57, 8'h03, 8'hA5, 3, 8'h4B, 0};
    v[1] = '{"rd3",   8'h52, 8'h03, 8'h00, 2, 8'hA5, 0};
    v[2] = '{"badop", 8'h41, 8'h00, 8'h00, 1, 8'h3F, 1};
    v[3] = '{"rd8",   8'h52, 8'h08, 8'h00, 2, 8'h3F, 1};
    v[4] = '{"wr7",   8'h57, 8'h07, 8'h3C, 3, 8'h4B, 0};
    v[5] = '{"rd7",   8'h52, 8'h07, 8'h00, 2, 8'h3C, 0};
    v[6] = '{"wr9",   8'h57, 8'h09, 8'hFF, 3, 8'h3F, 1};
    v[7] = '{"rd0",   8'h52, 8'h00, 8'h00, 2, 8'h00, 0};

    repeat (3) @(negedge clk);
    check("rst tx_push", 64'(tx_push), 64'd0);
    check("rst rx_pop", 64'(rx_pop), 64'd0);
    check("rst tx_byte", 64'(tx_byte), 64'd0);
    check("rst regs", regs_out, 64'd0);
    check("rst err_count", 64'(err_count), 64'd0);
    check("rst busy_err", 64'({busy, cmd_err}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_cmd(v[i].name, v[i].b0, v[i].b1, v[i].b2, v[i].n, v[i].reply, v[i].err);

    // timeout inside a write packet: error, no reply, packet dropped
    p0 = push_cnt;
    e0 = err_cnt;
    send_bytes(8'h57, 8'h01, 8'h00, 2);
    repeat (14) @(negedge clk);
    check("tmo early_err", 64'(err_cnt - e0), 64'd0);
    repeat (30) @(negedge clk);
    merr = merr + 1;
    check("tmo err_pulses", 64'(err_cnt - e0), 64'd1);
    check("tmo no_push", 64'(push_cnt - p0), 64'd0);
    check("tmo err_count", 64'(err_count), 64'(merr));
    check("tmo busy", 64'(busy), 64'd0);
    do_cmd("tmo rd1", 8'h52, 8'h01, 8'h00, 2, 8'h00, 0);

    // TX backpressure while in SEND
    tx_full = 1'b1;
    p0 = push_cnt;
    send_bytes(8'h52, 8'h03, 8'h00, 2);
    repeat (20) @(negedge clk);
    check("full no_push", 64'(push_cnt - p0), 64'd0);
    check("full busy", 64'(busy), 64'd1);
    tx_full = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_push) begin ok = 1; break; end
    end
    check("full push_seen", 64'(ok), 64'd1);
    check("full tx_byte", 64'(tx_byte), 64'hA5);
    @(negedge clk);
    check("full busy_drop", 64'(busy), 64'd0);
    check("full push_width", 64'(tx_push), 64'd0);
    repeat (4) @(negedge clk);
    check("full push_count", 64'(push_cnt - p0), 64'd1);

    // reset in the middle of a write packet
    send_bytes(8'h57, 8'h00, 8'h00, 1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    merr = 0;
    check("mrst regs", regs_out, 64'd0);
    check("mrst err_count", 64'(err_count), 64'd0);
    check("mrst outs", 64'({tx_push, rx_pop, cmd_err, busy}), 64'd0);
    check("mrst tx_byte", 64'(tx_byte), 64'd0);
    do_cmd("mrst wr2", 8'h57, 8'h02, 8'h11, 3, 8'h4B, 0);

    check("cmd_err width", 64'(wide_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
